cen_mean_sub: RTL and testbench
===============================

# cen_mean_sub

Centering control-and-subtract stage of the whitening front end. Collects a frame of N four-channel samples and streams them into the 4-channel centering accumulator while buffering them locally. It then reads the frame sums back, forms the per-channel mean, and replays the buffered frame as mean-removed, saturated samples to the downstream whitening-matrix stage. It owns the accumulator's enable and input lines; the accumulator itself is external.

## Interface
Parameters:
- DW, 16, sample width (signed).
- LOG2N, 5, log2 of frame length; N = 2^LOG2N samples per frame.
- SW, DW+LOG2N (21), accumulator sum width; must equal the accumulator's sum width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a frame; sampled only in IDLE.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts a sample this cycle.
- x1_in..x4_in  in  DW each  signed input channels.
- adder_en  out  1  accumulator enable; low clears the accumulator.
- adder_x1..adder_x4  out  DW each  signed accumulator inputs.
- adder_sum1..adder_sum4  in  SW each  signed accumulator sums.
- out_valid  out  1  centered sample valid.
- out_ready  in  1  downstream accepts the sample.
- c1_out..c4_out  out  DW each  signed centered channels.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on the final output handshake of a frame.

## Operation
- Clock and reset: one clock domain; reset asynchronous active-low as fixed above.
- States: IDLE, COLLECT, MEAN, DRAIN.
- IDLE: in_ready=0, adder_en=0. On start=1, go to COLLECT and clear wr_ptr, rd_ptr.
- COLLECT:
  - in_ready=1, adder_en=1.
  - A sample is accepted when in_valid=1. It is written to buffer[wr_ptr] (N entries of 4×DW), and adder_xk=xk_in.
  - On non-accepting cycles, adder_xk=0, so the accumulator holds its sums.
  - The N-th accept (wr_ptr=N-1) moves the FSM to MEAN.
- MEAN (exactly 1 cycle):
  - adder_en=1, adder_xk=0.
  - Latch meank = (adder_sumk + 2^(LOG2N-1)) >>> LOG2N, arithmetic shift with round-half-up, truncated to DW. The result always fits DW.
  - Go to DRAIN. adder_en falls there and clears the accumulator.
- DRAIN:
  - adder_en=0, adder_xk=0.
  - The output register loads whenever out_valid=0 or out_ready=1, while rd_ptr<N.
  - Each load: ck_out = sat_DW(buffer[rd_ptr].xk − meank). The difference is computed in DW+1 bits, then clamped to [−2^(DW−1), 2^(DW−1)−1]. rd_ptr then increments.
  - On the handshake of sample N−1: done=1 for 1 cycle, out_valid drops (unless reloaded, which cannot happen), FSM returns to IDLE.
- start outside IDLE is ignored. in_valid outside COLLECT is ignored (in_ready=0).
- Samples leave in arrival order; no reordering or dropping.

## Timing
- Reset values: in_ready=0, adder_en=0, adder_x1..4=0, out_valid=0, c1..4_out=0, busy=0, done=0, state=IDLE, pointers=0, means=0.
- start at edge t → COLLECT from t+1. The earliest first accept is cycle t+1.
- Last accept at edge a → MEAN in cycle a+1, where the sums are valid. DRAIN begins at a+2; the first out_valid=1 is at a+3.
- With out_ready held high, DRAIN sustains 1 sample/cycle. Frame output spans cycles a+3 .. a+2+N, and done coincides with the last handshake.
- Backpressure: while out_valid=1 and out_ready=0, c*_out and out_valid hold stable.
- adder_xk is combinational from xk_in and in_valid in COLLECT.
- adder_en is registered from state: high exactly in COLLECT and MEAN.
- Reset mid-operation: everything returns to reset values immediately. adder_en=0 clears the accumulator, and the partial frame is discarded.
- A back-to-back frame needs start in the IDLE cycle after done; the minimum gap is 1 cycle.

## Test plan
- Constant: defaults, all channels =100 for 32 samples, out_ready=1 → 32 outputs of 0, done once, in_ready low outside COLLECT.
- Ramp: xk = sample index 0..31 → sum 496, mean 16 → outputs −16..15 in order.
- Negative rounding: 31 samples of −1 then one 0 → sum −31, mean −1 → outputs 0 (×31) then 1.
- Saturation: x4 = 32767 first, then −32768 ×31 → sum −983041, mean −30720 → first c4_out=32767 (clamped), remaining −2048.
- Flow control: in_valid random 50% and out_ready random 50% → outputs identical to the ramp case. The accumulator sum is unchanged on idle cycles, and outputs stay stable while stalled.
- Reset mid-COLLECT after 10 samples, then a new full frame of constant 5 → adder_en drops at reset, outputs all 0, no stale data.

Source files
------------

// File: rtl/cen_mean_sub_if.sv
// Sample-in, accumulator and centered-out lines of the centering stage.
// The slave modport is the stage's own view of these lines; master is the environment's view.
interface cen_mean_sub_if #(
  parameter int DW = 16,
  parameter int SW = 21
);
  logic                 start;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] x1_in, x2_in, x3_in, x4_in;
  logic                 adder_en;
  logic signed [DW-1:0] adder_x1, adder_x2, adder_x3, adder_x4;
  logic signed [SW-1:0] adder_sum1, adder_sum2, adder_sum3, adder_sum4;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] c1_out, c2_out, c3_out, c4_out;
  logic                 busy;
  logic                 done;

  modport slave (
    input  start, in_valid, x1_in, x2_in, x3_in, x4_in,
    input  adder_sum1, adder_sum2, adder_sum3, adder_sum4, out_ready,
    output in_ready, adder_en, adder_x1, adder_x2, adder_x3, adder_x4,
    output out_valid, c1_out, c2_out, c3_out, c4_out, busy, done
  );

  modport master (
    output start, in_valid, x1_in, x2_in, x3_in, x4_in,
    output adder_sum1, adder_sum2, adder_sum3, adder_sum4, out_ready,
    input  in_ready, adder_en, adder_x1, adder_x2, adder_x3, adder_x4,
    input  out_valid, c1_out, c2_out, c3_out, c4_out, busy, done
  );
endinterface

// File: rtl/cen_mean_sub.sv
// Frame collector and mean-removal stage: feeds an external accumulator while buffering
// a frame, then replays the frame minus the rounded per-channel mean, saturated to DW.
module cen_mean_sub #(
  parameter int DW    = 16,
  parameter int LOG2N = 5,
  parameter int SW    = DW + LOG2N
) (
  input logic           clk,
  input logic           rst_n,
  cen_mean_sub_if.slave bus
);
  localparam int N = 1 << LOG2N;
  localparam logic signed [SW:0]   HALF    = (SW+1)'(N / 2);
  localparam logic signed [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COLLECT, MEAN, DRAIN} state_e;

  state_e               state_q, state_d;
  logic [LOG2N-1:0]     wr_ptr_q;
  logic [LOG2N:0]       rd_ptr_q;
  logic                 adder_en_q;
  logic                 out_valid_q;
  logic signed [DW-1:0] mean_q [4];
  logic signed [DW-1:0] c_q    [4];
  logic [4*DW-1:0]      buf_mem [N];

  logic signed [DW-1:0] x_in    [4];
  logic signed [SW-1:0] sum_in  [4];
  logic signed [DW-1:0] buf_x   [4];
  logic signed [SW:0]   rounded [4];
  logic signed [DW:0]   diff    [4];
  logic signed [DW-1:0] mean_d  [4];
  logic signed [DW-1:0] c_d     [4];
  logic [4*DW-1:0]      rd_word;
  logic                 accept, load, last_hs;

  assign x_in   = '{bus.x1_in, bus.x2_in, bus.x3_in, bus.x4_in};
  assign sum_in = '{bus.adder_sum1, bus.adder_sum2, bus.adder_sum3, bus.adder_sum4};

  assign accept  = (state_q == COLLECT) && bus.in_valid;
  assign load    = (state_q == DRAIN) && (!out_valid_q || bus.out_ready)
                   && (rd_ptr_q < (LOG2N+1)'(N));
  // rd_ptr reaching N means every sample is loaded; the handshake now is the frame's last.
  assign last_hs = (state_q == DRAIN) && out_valid_q && bus.out_ready
                   && (rd_ptr_q == (LOG2N+1)'(N));
  assign rd_word = buf_mem[rd_ptr_q[LOG2N-1:0]];

  // NOTE: every variable is assigned on every path of a combinational block, so no latch can form.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = COLLECT;
      COLLECT: if (accept && wr_ptr_q == LOG2N'(N - 1)) state_d = MEAN;
      MEAN:    state_d = DRAIN;
      DRAIN:   if (last_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      buf_x[k]   = rd_word[k*DW +: DW];
      rounded[k] = $signed({sum_in[k][SW-1], sum_in[k]}) + HALF;
      mean_d[k]  = DW'(rounded[k] >>> LOG2N);
      diff[k]    = $signed({buf_x[k][DW-1], buf_x[k]}) - $signed({mean_q[k][DW-1], mean_q[k]});
      if (diff[k][DW] != diff[k][DW-1]) c_d[k] = diff[k][DW] ? SAT_MIN : SAT_MAX;
      else                              c_d[k] = diff[k][DW-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      adder_en_q  <= 1'b0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        mean_q[k] <= '0;
        c_q[k]    <= '0;
      end
    end else begin
      state_q    <= state_d;
      adder_en_q <= (state_d == COLLECT) || (state_d == MEAN);
      if (state_q == IDLE && bus.start) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end
      if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (state_q == MEAN) mean_q <= mean_d;
      if (load) begin
        c_q         <= c_d;
        rd_ptr_q    <= rd_ptr_q + 1'b1;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // NOTE: the frame buffer has no reset; each entry is written before it is read back.
  always_ff @(posedge clk) begin
    if (accept) buf_mem[wr_ptr_q] <= {x_in[3], x_in[2], x_in[1], x_in[0]};
  end

  // Zero inputs on idle cycles keep the accumulator sums frozen.
  assign bus.adder_x1  = accept ? x_in[0] : '0;
  assign bus.adder_x2  = accept ? x_in[1] : '0;
  assign bus.adder_x3  = accept ? x_in[2] : '0;
  assign bus.adder_x4  = accept ? x_in[3] : '0;
  assign bus.adder_en  = adder_en_q;
  assign bus.in_ready  = (state_q == COLLECT);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = last_hs;
  assign bus.out_valid = out_valid_q;
  assign bus.c1_out    = c_q[0];
  assign bus.c2_out    = c_q[1];
  assign bus.c3_out    = c_q[2];
  assign bus.c4_out    = c_q[3];
endmodule

// File: tb/tb_cen_mean_sub.sv
// Directed bench for cen_mean_sub with a behavioural accumulator, a frame-level mean/saturation
// model and a per-cycle output compare process.
module tb_cen_mean_sub;
  localparam int DW = 16, LOG2N = 5, N = 32, SW = 21;

  typedef logic [3:0][DW-1:0] vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cen_mean_sub_if #(.DW(DW), .SW(SW)) bus ();
  cen_mean_sub #(.DW(DW), .LOG2N(LOG2N), .SW(SW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // External accumulator: clears while adder_en is low, otherwise adds adder_x every cycle.
  logic signed [SW-1:0] acc [4];
  always @(posedge clk) begin
    if (!bus.adder_en) begin
      for (int k = 0; k < 4; k++) acc[k] <= '0;
    end else begin
      acc[0] <= acc[0] + SW'(bus.adder_x1);
      acc[1] <= acc[1] + SW'(bus.adder_x2);
      acc[2] <= acc[2] + SW'(bus.adder_x3);
      acc[3] <= acc[3] + SW'(bus.adder_x4);
    end
  end
  assign bus.adder_sum1 = acc[0];
  assign bus.adder_sum2 = acc[1];
  assign bus.adder_sum3 = acc[2];
  assign bus.adder_sum4 = acc[3];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int rdy_pct = 100;
  int frame_x [N][4];
  longint exp_sum [4];
  vec_t expq [$];
  vec_t gotq [$];
  int first_edge = -1, done_edge = -1, done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Frame model: rounded-half-up mean by floor division, then clamped difference.
  task automatic build_expected();
    longint s, q, d;
    longint m [4];
    vec_t v;
    for (int k = 0; k < 4; k++) begin
      s = 0;
      for (int i = 0; i < N; i++) s += frame_x[i][k];
      exp_sum[k] = s;
      q = s + N / 2;
      m[k] = (q >= 0) ? q / N : -((-q + N - 1) / N);
    end
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 4; k++) begin
        d = frame_x[i][k] - m[k];
        if (d > 32767) d = 32767;
        if (d < -32768) d = -32768;
        v[k] = DW'(d);
      end
      expq.push_back(v);
    end
  endtask

  task automatic fill_frame(input int kind, input int val);
    for (int i = 0; i < N; i++) begin
      case (kind)
        0: frame_x[i] = '{val, val, val, val};
        1: frame_x[i] = '{i, 31 - i, 3 * i - 50, -100 * i};
        2: frame_x[i] = (i < 31) ? '{-1, -1, -1, -1} : '{0, 0, 0, 0};
        default: frame_x[i] = '{(i == 0) ? -32768 : 32767, 7 * i, -i,
                                (i == 0) ? 32767 : -32768};
      endcase
    end
  endtask

  // Output compare: every cycle outside reset, away from the rising edge.
  logic hold_valid = 1'b0;
  vec_t hold_data, cur, e;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_valid = 1'b0;
    end else begin
      cur = {bus.c4_out, bus.c3_out, bus.c2_out, bus.c1_out};
      if (hold_valid) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_data", cur, hold_data);
      end
      hold_valid = bus.out_valid && !bus.out_ready;
      hold_data  = cur;
      if (bus.out_valid) check("in_ready_in_drain", bus.in_ready, 0);
      if (bus.out_valid && bus.out_ready) begin
        check("output_expected", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          for (int k = 0; k < 4; k++)
            check($sformatf("c%0d_out", k + 1), $signed(cur[k]), $signed(e[k]));
          check("done_on_last", bus.done, expq.size() == 0);
        end
        gotq.push_back(cur);
        if (first_edge < 0) first_edge = cyc + 1;
        if (bus.done) begin
          done_edge = cyc + 1;
          done_cnt++;
        end
      end else begin
        check("done_idle", bus.done, 0);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      bus.out_ready = ($urandom_range(99) < rdy_pct);
    end
  end

  task automatic drive_x(input int i);
    bus.x1_in = DW'(frame_x[i][0]);
    bus.x2_in = DW'(frame_x[i][1]);
    bus.x3_in = DW'(frame_x[i][2]);
    bus.x4_in = DW'(frame_x[i][3]);
  endtask

  // One frame: start, feed N samples (or abort_at samples then reset), wait for done.
  task automatic run_frame(input int vpct, input int rpct, input int abort_at, input bit chk_lat);
    int idx = 0;
    int budget = 0;
    int a_edge = -1;
    rdy_pct = rpct;
    gotq.delete();
    first_edge = -1; done_edge = -1; done_cnt = 0;
    if (abort_at < 0) build_expected();
    @(posedge clk); #1; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    while (idx < N && budget < 2000) begin
      bus.in_valid = ($urandom_range(99) < vpct);
      drive_x(idx);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        check("adder_x1", bus.adder_x1, frame_x[idx][0]);
        check("adder_x4", bus.adder_x4, frame_x[idx][3]);
        idx++;
        if (idx == N) a_edge = cyc + 1;
      end else if (bus.in_ready) begin
        check("adder_x_idle", {bus.adder_x1, bus.adder_x2, bus.adder_x3, bus.adder_x4}, 0);
      end
      if (abort_at >= 0 && idx == abort_at) break;
      @(posedge clk); #1;
      budget++;
    end
    if (abort_at >= 0) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_adder_en", bus.adder_en, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      return;
    end
    bus.in_valid = 1'b0;
    check("inputs_accepted", idx, N);
    @(negedge clk);
    check("mean_adder_en", bus.adder_en, 1);
    check("sum1", bus.adder_sum1, exp_sum[0]);
    check("sum2", bus.adder_sum2, exp_sum[1]);
    check("sum3", bus.adder_sum3, exp_sum[2]);
    check("sum4", bus.adder_sum4, exp_sum[3]);
    budget = 0;
    while (done_edge < 0 && budget < 8 * N + 50) begin
      @(posedge clk);
      budget++;
    end
    check("frame_done_seen", done_edge >= 0, 1);
    check("output_count", gotq.size(), N);
    check("done_count", done_cnt, 1);
    if (chk_lat) begin
      check("first_out_latency", first_edge - a_edge, 3);
      check("done_latency", done_edge - a_edge, N + 2);
    end
    @(negedge clk);
    check("idle_busy", bus.busy, 0);
    check("idle_in_ready", bus.in_ready, 0);
    check("idle_adder_en", bus.adder_en, 0);
  endtask

  initial begin
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.x1_in = '0; bus.x2_in = '0; bus.x3_in = '0; bus.x4_in = '0;
    #2;
    check("reset_in_ready", bus.in_ready, 0);
    check("reset_adder_en", bus.adder_en, 0);
    check("reset_adder_x", {bus.adder_x1, bus.adder_x2, bus.adder_x3, bus.adder_x4}, 0);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_c_out", {bus.c1_out, bus.c2_out, bus.c3_out, bus.c4_out}, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    fill_frame(0, 100);
    run_frame(100, 100, -1, 1'b1);
    if (gotq.size() == N) check("const_first", $signed(gotq[0][0]), 0);

    fill_frame(1, 0);
    run_frame(100, 100, -1, 1'b1);
    if (gotq.size() == N) begin
      check("ramp_first", $signed(gotq[0][0]), -16);
      check("ramp_last", $signed(gotq[N-1][0]), 15);
    end

    fill_frame(2, 0);
    run_frame(100, 100, -1, 1'b0);
    if (gotq.size() == N) begin
      check("negrnd_first", $signed(gotq[0][2]), 0);
      check("negrnd_last", $signed(gotq[N-1][2]), 1);
    end

    fill_frame(3, 0);
    run_frame(100, 100, -1, 1'b0);
    if (gotq.size() == N) begin
      check("sat_c4_first", $signed(gotq[0][3]), 32767);
      check("sat_c4_rest", $signed(gotq[1][3]), -2048);
      check("sat_c1_first", $signed(gotq[0][0]), -32768);
    end

    fill_frame(1, 0);
    run_frame(50, 50, -1, 1'b0);
    if (gotq.size() == N) check("flow_last", $signed(gotq[N-1][0]), 15);

    fill_frame(1, 0);
    run_frame(100, 100, 10, 1'b0);
    fill_frame(0, 5);
    run_frame(100, 100, -1, 1'b1);
    if (gotq.size() == N) check("after_reset_first", $signed(gotq[0][1]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected to finish", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
